// File: rtl/antilog_16.sv
// Two-stage base-2 antilog: 17-bit log word (Q5.12, signed integer part) to
// unsigned Q4.12 linear value by Mitchell approximation, with saturation counters.
module antilog_16 #(
    parameter int WIDTH = 16,
    parameter int QP    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_log,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_unf,
    output logic [7:0]       ovf_cnt,
    output logic [7:0]       unf_cnt
);

    logic          en1, en2;
    logic [5:0]    shift_d;
    logic          ovf_d, unf_d;

    logic          s1_valid;
    logic [5:0]    s1_shift;
    logic [QP:0]   s1_mant;
    logic          s1_zero, s1_ovf, s1_unf;

    logic [WIDTH-1:0] mant_ext;
    logic [WIDTH-1:0] res_d;
    logic             out_xfer;

    always_comb begin
        en2      = ~out_valid | out_ready;
        en1      = ~s1_valid | en2;
        in_ready = en1;
        out_xfer = out_valid & out_ready;
    end

    // Shift is the sign-extended integer part biased by the fraction width.
    always_comb begin
        shift_d = {in_log[WIDTH], in_log[WIDTH:QP]} + 6'd12;
        ovf_d   = ~in_zero & ($signed(shift_d) > 6'sd15);
        unf_d   = ~in_zero & shift_d[5];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            s1_mant  <= '0;
            s1_zero  <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_unf   <= 1'b0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_shift <= shift_d;
                s1_mant  <= {1'b1, in_log[QP-1:0]};
                s1_zero  <= in_zero;
                s1_ovf   <= ovf_d;
                s1_unf   <= unf_d;
            end
        end
    end

    always_comb begin
        mant_ext = {{(WIDTH-QP-1){1'b0}}, s1_mant};
        res_d    = '0;
        if (s1_zero || s1_unf)
            res_d = '0;
        else if (s1_ovf)
            res_d = '1;
        else if ($signed(s1_shift) >= 6'sd12)
            res_d = mant_ext << (s1_shift - 6'd12);
        else
            res_d = mant_ext >> (6'd12 - s1_shift);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_d;
                out_ovf  <= s1_ovf;
                out_unf  <= s1_unf;
            end
        end
    end

    // Events are counted as results leave, so stalled words are counted once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (out_xfer) begin
            if (out_ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            if (out_unf && unf_cnt != 8'hFF) unf_cnt <= unf_cnt + 8'd1;
        end
    end

endmodule
